lru_way_age_bank: RTL and testbench

Per-way age-state bank for the LRU eviction path: the way-side responder to the LRU eviction policy's broadcast of the accessed way and its age. It holds one age counter per way and updates all counters in one cycle on each access or invalidate. It reports every way's age back to the policy, plus the one-hot expired (LRU victim) vector and per-way valid bits. It sits between the set's tag/data ways and the LRU eviction policy, one instance per set.

---
 rtl/lru_way_age_bank_pkg.sv | 23 ++
 rtl/lru_way_age_bank_onehot.sv | 22 ++
 rtl/lru_way_age_bank.sv | 94 +++++++++
 tb/tb_lru_way_age_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lru_way_age_bank_pkg.sv
// Shared helpers for the LRU way-age bank: counter sizing, reset ordering
// and the one-hot legality check used on the broadcast accessed-way vector.
package lru_pkg;

  // Widest accessed-way vector the one-hot check accepts; callers zero-extend.
  localparam int MAX_WAYS = 1024;

  // Age counter width for a set of n ways (n is a power of two, n >= 2).
  function automatic int clog2_ways(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Age held by way i after reset: way 0 is the oldest, so it is the first victim.
  function automatic int reset_age(input int i, input int n);
    return n - 1 - i;
  endfunction

  // True when exactly one bit of vec is set.
  function automatic logic onehot_ok(input logic [MAX_WAYS-1:0] vec);
    return ($countones(vec) == 1);
  endfunction

endpackage

// File: rtl/lru_way_age_bank_onehot.sv
// Converts the policy's one-hot accessed-way vector into a way index, and
// flags whether the vector really was one-hot so the access can be rejected.
module lru_onehot_to_index import lru_pkg::*; #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] idx_o,
  output logic         onehot_o
);

  // OR together the indices of all set bits; only meaningful when onehot_o is high.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) idx_o = idx_o | W'(i);
    end
  end

  assign onehot_o = onehot_ok(MAX_WAYS'(onehot_i));

endmodule

// File: rtl/lru_way_age_bank.sv
// Per-set bank of way age counters. Ages are kept as a permutation of
// 0..NUM_WAYS-1; the way at age NUM_WAYS-1 is the eviction victim.
// An access promotes a way to age 0, an invalidate demotes it to the oldest
// slot, and the ways between shift by one so the permutation is preserved.
module lru_way_age_bank import lru_pkg::*; #(
  parameter  int NUM_WAYS      = 512,
  localparam int COUNTER_WIDTH = clog2_ways(NUM_WAYS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              access_valid,
  input  logic [NUM_WAYS-1:0]               accessed,
  input  logic [COUNTER_WIDTH-1:0]          accessed_way_age,
  input  logic                              invalidate_valid,
  input  logic [COUNTER_WIDTH-1:0]          invalidate_way,
  output logic                              invalidate_ready,
  output logic [NUM_WAYS*COUNTER_WIDTH-1:0] my_age,
  output logic [NUM_WAYS-1:0]               expired,
  output logic [NUM_WAYS-1:0]               way_valid,
  output logic                              protocol_error
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] AGE_ONE    = W'(1);
  localparam logic [W-1:0] AGE_OLDEST = W'(NUM_WAYS - 1);

  logic [NUM_WAYS-1:0][W-1:0] age_q, age_d;
  logic [NUM_WAYS-1:0]        valid_q, valid_d;
  logic                       err_q, err_d;

  logic [W-1:0] acc_idx;
  logic         acc_onehot;
  logic         acc_ok;
  logic         inv_fire;
  logic [W-1:0] inv_age;

  lru_onehot_to_index #(
    .N (NUM_WAYS),
    .W (W)
  ) u_onehot_to_index (
    .onehot_i (accessed),
    .idx_o    (acc_idx),
    .onehot_o (acc_onehot)
  );

  // An access is applied only if the vector is one-hot and the broadcast age
  // matches what we hold; anything else would break the permutation.
  assign acc_ok           = access_valid && acc_onehot && (age_q[acc_idx] == accessed_way_age);
  assign invalidate_ready = !access_valid;
  assign inv_fire         = invalidate_valid && invalidate_ready;
  assign inv_age          = age_q[invalidate_way];
  assign err_d            = err_q || (access_valid && !acc_ok);

  // Per-way next age/valid: one compare against the accessed age, one against the target age.
  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
    localparam logic [W-1:0] IDX = W'(i);
    logic is_target;
    assign is_target = (invalidate_way == IDX);

    assign age_d[i] = acc_ok   ? (accessed[i]                     ? '0
                                 : (age_q[i] < accessed_way_age) ? age_q[i] + AGE_ONE
                                 :                                   age_q[i])
                    : inv_fire ? (is_target                       ? AGE_OLDEST
                                 : (age_q[i] > inv_age)          ? age_q[i] - AGE_ONE
                                 :                                   age_q[i])
                    : age_q[i];

    assign valid_d[i] = (acc_ok && accessed[i])  ? 1'b1
                      : (inv_fire && is_target)  ? 1'b0
                      :                            valid_q[i];

    assign expired[i] = (age_q[i] == AGE_OLDEST);
  end

  // State registers; reset restores the descending age order and clears valid/error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        age_q[i] <= W'(reset_age(i, NUM_WAYS));
      end
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      age_q   <= age_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign my_age         = age_q;
  assign way_valid      = valid_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_lru_way_age_bank.sv
// Bench for lru_way_age_bank with four ways. The reference model keeps the
// ways as a recency list (most recent first); a way's age is its position.
module tb_lru_way_age_bank;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           access_valid;
  logic [N-1:0]   accessed;
  logic [W-1:0]   accessed_way_age;
  logic           invalidate_valid;
  logic [W-1:0]   invalidate_way;
  logic           invalidate_ready;
  logic [N*W-1:0] my_age;
  logic [N-1:0]   expired;
  logic [N-1:0]   way_valid;
  logic           protocol_error;

  lru_way_age_bank #(.NUM_WAYS(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .access_valid     (access_valid),
    .accessed         (accessed),
    .accessed_way_age (accessed_way_age),
    .invalidate_valid (invalidate_valid),
    .invalidate_way   (invalidate_way),
    .invalidate_ready (invalidate_ready),
    .my_age           (my_age),
    .expired          (expired),
    .way_valid        (way_valid),
    .protocol_error   (protocol_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: recency list and valid bits.
  int         order[$];
  logic [N-1:0] m_valid;
  logic         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_age(input int w);
    for (int p = 0; p < order.size(); p++) if (order[p] == w) return p;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] model_ages();
    logic [N*W-1:0] a = '0;
    for (int w = 0; w < N; w++) a[w*W +: W] = W'(model_age(w));
    return a;
  endfunction

  function automatic logic [N-1:0] model_expired();
    logic [N-1:0] e = '0;
    for (int w = 0; w < N; w++) e[w] = (model_age(w) == N - 1);
    return e;
  endfunction

  task automatic model_reset();
    order = {3, 2, 1, 0};
    m_valid = '0;
    m_err = 1'b0;
  endtask

  task automatic model_remove(input int w);
    for (int p = 0; p < order.size(); p++) if (order[p] == w) begin order.delete(p); break; end
  endtask

  task automatic model_access(input int w);
    model_remove(w);
    order.push_front(w);
    m_valid[w] = 1'b1;
  endtask

  task automatic model_invalidate(input int w);
    model_remove(w);
    order.push_back(w);
    m_valid[w] = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_age"},   32'(my_age),         32'(model_ages()));
    check({tag, "_exp"},   32'(expired),        32'(model_expired()));
    check({tag, "_valid"}, 32'(way_valid),      32'(m_valid));
    check({tag, "_err"},   32'(protocol_error), 32'(m_err));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; access_valid = 1'b0; accessed = '0; accessed_way_age = '0;
    invalidate_valid = 1'b0; invalidate_way = '0;
  endtask

  typedef struct {
    string        name;
    logic         acc_v;
    logic [N-1:0] acc;
    logic [W-1:0] acc_age;
    logic         inv_v;
    logic [W-1:0] inv_way;
    logic [7:0]   exp_age;
    logic [N-1:0] exp_expired;
    logic [N-1:0] exp_valid;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Ages packed way3..way0 from MSB; hand-derived from the access/invalidate rules.
    vecs[0] = '{"acc_w0",      1, 4'b0001, 2'd3, 0, 2'd0, 8'h6C, 4'b0010, 4'b0001, 0};
    vecs[1] = '{"acc_w2",      1, 4'b0100, 2'd2, 0, 2'd0, 8'h8D, 4'b0010, 4'b0101, 0};
    vecs[2] = '{"inv_w2",      0, 4'b0000, 2'd0, 1, 2'd2, 8'h78, 4'b0100, 4'b0001, 0};
    vecs[3] = '{"not_onehot",  1, 4'b0011, 2'd0, 0, 2'd0, 8'h78, 4'b0100, 4'b0001, 1};
    vecs[4] = '{"wrong_age",   1, 4'b0001, 2'd2, 0, 2'd0, 8'h78, 4'b0100, 4'b0001, 1};
    vecs[5] = '{"acc_w1_err",  1, 4'b0010, 2'd2, 0, 2'd0, 8'hB1, 4'b0100, 4'b0011, 1};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_age",   32'(my_age),           32'h1B);
    check("rst_exp",   32'(expired),          32'b0001);
    check("rst_valid", 32'(way_valid),        32'b0000);
    check("rst_err",   32'(protocol_error),   32'd0);
    check("rst_ready", 32'(invalidate_ready), 32'd1);

    // Directed table from reset.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      access_valid = vecs[k].acc_v; accessed = vecs[k].acc; accessed_way_age = vecs[k].acc_age;
      invalidate_valid = vecs[k].inv_v; invalidate_way = vecs[k].inv_way;
      @(posedge clk); #1;
      idle_inputs();
      check({vecs[k].name, "_age"},   32'(my_age),         32'(vecs[k].exp_age));
      check({vecs[k].name, "_exp"},   32'(expired),        32'(vecs[k].exp_expired));
      check({vecs[k].name, "_valid"}, 32'(way_valid),      32'(vecs[k].exp_valid));
      check({vecs[k].name, "_err"},   32'(protocol_error), 32'(vecs[k].exp_err));
    end

    // Reset in the same cycle as a legal access: reset wins.
    @(negedge clk);
    reset = 1'b1; access_valid = 1'b1; accessed = 4'b0100; accessed_way_age = 2'd3;
    @(posedge clk); #1;
    idle_inputs();
    model_reset();
    check_model("rst_with_acc");

    // Access and invalidate held together: invalidate stalls, then completes.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      access_valid = 1'b1; accessed = N'(1) << (c + 1); accessed_way_age = W'(model_age(c + 1));
      invalidate_valid = 1'b1; invalidate_way = 2'd1;
      #1;
      check("stall_ready", 32'(invalidate_ready), 32'd0);
      @(posedge clk); #1;
      model_access(c + 1);
      check_model("stall");
    end
    @(negedge clk);
    access_valid = 1'b0; accessed = '0;
    #1;
    check("stall_release_ready", 32'(invalidate_ready), 32'd1);
    @(posedge clk); #1;
    model_invalidate(1);
    check_model("stall_done");
    idle_inputs();

    // Random legal traffic against the recency-list model.
    for (int n = 0; n < 10000; n++) begin
      int op, w, iw;
      @(negedge clk);
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, N - 1);
      iw = $urandom_range(0, N - 1);
      access_valid = op[0]; accessed = N'(1) << w; accessed_way_age = W'(model_age(w));
      invalidate_valid = op[1]; invalidate_way = W'(iw);
      #1;
      check("rnd_ready", 32'(invalidate_ready), 32'(!op[0]));
      @(posedge clk); #1;
      if (op[0]) model_access(w);
      else if (op[1]) model_invalidate(iw);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
